// File: rtl/hud_counter_bank.sv
// hud_counter_bank: HUD counter bank for Super Gene Bros.
//   Score: BCD counter of SCORE_DIGITS digits, updated by a digit-serial BCD
//          adder behind a valid/ready handshake; saturates at all nines.
//   Coins: two BCD digits; 99 -> 00 rolls over into lives (1-up).
//   Lives: binary, saturating at LIVES_MAX.
//   Debug: 8-bit host byte latch.
// Ports:
//   clk, reset_n (sync, active-low), clear (sync game clear)
//   add_valid/add_ready/add_bcd : score-add handshake and BCD amount
//   coin_inc                    : one-cycle coin pulse
//   debug_we/debug_in/debug_q   : debug byte latch
//   score_bcd, coin_bcd, lives  : registered counter values
//   oneup, score_sat            : one-cycle event pulses
//   score_blank, coin_blank     : leading-zero masks for the digit drivers
module hud_counter_bank #(
  parameter int SCORE_DIGITS = 4,
  parameter int LIVES_INIT   = 3,
  parameter int LIVES_MAX    = 9,
  parameter int BLANK_LZ     = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic                      add_valid,
  output logic                      add_ready,
  input  logic [4*SCORE_DIGITS-1:0] add_bcd,
  input  logic                      coin_inc,
  input  logic                      debug_we,
  input  logic [7:0]                debug_in,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic [7:0]                coin_bcd,
  output logic [3:0]                lives,
  output logic [7:0]                debug_q,
  output logic                      oneup,
  output logic                      score_sat,
  output logic [SCORE_DIGITS-1:0]   score_blank,
  output logic [1:0]                coin_blank
);

  localparam int SW    = 4 * SCORE_DIGITS;
  localparam int IDX_W = (SCORE_DIGITS > 1) ? $clog2(SCORE_DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, ADD, COMMIT} state_t;

  state_t           state_reg;
  logic [SW-1:0]    score_reg;
  logic [SW-1:0]    op_reg;
  logic [SW-1:0]    work_reg;
  logic [SW-1:0]    add_clamped;
  logic [IDX_W-1:0] idx_reg;
  logic             carry_reg;
  logic             add_ready_reg;
  logic             score_sat_reg;

  logic [7:0]       coin_reg;
  logic [3:0]       lives_reg;
  logic             oneup_reg;
  logic [7:0]       debug_reg;

  logic [3:0]       cur_digit;
  logic [3:0]       op_digit;
  logic [4:0]       digit_sum;
  logic [4:0]       digit_adj;

  // Out-of-range BCD digits in the request are treated as 9.
  genvar gi;
  generate
    for (gi = 0; gi < SCORE_DIGITS; gi++) begin : g_clamp
      assign add_clamped[4*gi +: 4] = (add_bcd[4*gi +: 4] > 4'd9) ? 4'd9 : add_bcd[4*gi +: 4];
    end
  endgenerate

  // One digit of the serial adder: the committed score digit plus the operand
  // digit selected by idx_reg. work_reg collects results so score_reg only
  // ever shows complete sums.
  always_comb begin
    cur_digit = score_reg[4*int'(idx_reg) +: 4];
    op_digit  = op_reg[4*int'(idx_reg) +: 4];
    digit_sum = {1'b0, cur_digit} + {1'b0, op_digit} + {4'b0000, carry_reg};
    digit_adj = digit_sum - 5'd10;
  end

  // Score FSM
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      state_reg     <= IDLE;
      add_ready_reg <= 1'b1;
      score_reg     <= '0;
      op_reg        <= '0;
      work_reg      <= '0;
      idx_reg       <= '0;
      carry_reg     <= 1'b0;
      score_sat_reg <= 1'b0;
    end else begin
      score_sat_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (add_valid && add_ready_reg) begin
            op_reg        <= add_clamped;
            idx_reg       <= '0;
            carry_reg     <= 1'b0;
            work_reg      <= '0;
            add_ready_reg <= 1'b0;
            state_reg     <= ADD;
          end
        end
        ADD: begin
          if (digit_sum > 5'd9) begin
            work_reg[4*int'(idx_reg) +: 4] <= digit_adj[3:0];
            carry_reg                      <= 1'b1;
          end else begin
            work_reg[4*int'(idx_reg) +: 4] <= digit_sum[3:0];
            carry_reg                      <= 1'b0;
          end
          idx_reg <= idx_reg + 1'b1;
          if (idx_reg == IDX_W'(SCORE_DIGITS - 1)) begin
            state_reg <= COMMIT;
          end
        end
        COMMIT: begin
          // A carry out of the top digit means overflow: pin at all nines.
          if (carry_reg) begin
            score_reg     <= {SCORE_DIGITS{4'h9}};
            score_sat_reg <= 1'b1;
          end else begin
            score_reg <= work_reg;
          end
          add_ready_reg <= 1'b1;
          state_reg     <= IDLE;
        end
        default: begin
          add_ready_reg <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  // Coins, lives and debug byte. Debug is only cleared by reset, not by clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      coin_reg  <= 8'h00;
      lives_reg <= 4'(LIVES_INIT);
      oneup_reg <= 1'b0;
      debug_reg <= 8'h00;
    end else begin
      if (debug_we) begin
        debug_reg <= debug_in;
      end
      if (clear) begin
        coin_reg  <= 8'h00;
        lives_reg <= 4'(LIVES_INIT);
        oneup_reg <= 1'b0;
      end else begin
        oneup_reg <= 1'b0;
        if (coin_inc) begin
          if (coin_reg == 8'h99) begin
            coin_reg  <= 8'h00;
            oneup_reg <= 1'b1;
            if (lives_reg < 4'(LIVES_MAX)) begin
              lives_reg <= lives_reg + 4'd1;
            end
          end else if (coin_reg[3:0] == 4'd9) begin
            coin_reg <= {coin_reg[7:4] + 4'd1, 4'd0};
          end else begin
            coin_reg <= {coin_reg[7:4], coin_reg[3:0] + 4'd1};
          end
        end
      end
    end
  end

  // Digit i is a leading zero when it and every digit above it are zero.
  generate
    for (gi = 0; gi < SCORE_DIGITS; gi++) begin : g_blank
      if (gi == 0) begin : g_lsd
        assign score_blank[gi] = 1'b0;
      end else begin : g_upper
        assign score_blank[gi] = (BLANK_LZ != 0) && (score_reg[SW-1:4*gi] == '0);
      end
    end
  endgenerate

  assign coin_blank = {(BLANK_LZ != 0) && (coin_reg[7:4] == 4'd0), 1'b0};

  assign add_ready = add_ready_reg;
  assign score_bcd = score_reg;
  assign score_sat = score_sat_reg;
  assign coin_bcd  = coin_reg;
  assign lives     = lives_reg;
  assign oneup     = oneup_reg;
  assign debug_q   = debug_reg;

endmodule

// File: tb/tb_hud_counter_bank.sv
// Testbench for hud_counter_bank (default parameters). A cycle-level model
// keeps the score, coins and lives as plain integers; every cycle all DUT
// outputs are compared against it on the falling edge.
module tb_hud_counter_bank;

  localparam int D    = 4;
  localparam int LINI = 3;
  localparam int LMAX = 9;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear = 1'b0;
  logic          add_valid = 1'b0;
  logic          add_ready;
  logic [4*D-1:0] add_bcd = '0;
  logic          coin_inc = 1'b0;
  logic          debug_we = 1'b0;
  logic [7:0]    debug_in = 8'h00;
  logic [4*D-1:0] score_bcd;
  logic [7:0]    coin_bcd;
  logic [3:0]    lives;
  logic [7:0]    debug_q;
  logic          oneup;
  logic          score_sat;
  logic [D-1:0]  score_blank;
  logic [1:0]    coin_blank;

  hud_counter_bank #(
    .SCORE_DIGITS(D), .LIVES_INIT(LINI), .LIVES_MAX(LMAX), .BLANK_LZ(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .add_valid(add_valid), .add_ready(add_ready), .add_bcd(add_bcd),
    .coin_inc(coin_inc), .debug_we(debug_we), .debug_in(debug_in),
    .score_bcd(score_bcd), .coin_bcd(coin_bcd), .lives(lives), .debug_q(debug_q),
    .oneup(oneup), .score_sat(score_sat),
    .score_blank(score_blank), .coin_blank(coin_blank)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int         m_score = 0;
  int         m_pend  = 0;
  int         m_busy  = 0;
  int         m_coins = 0;
  int         m_lives = LINI;
  logic [7:0] m_debug = 8'h00;
  bit         m_oneup = 1'b0;
  bit         m_sat   = 1'b0;
  int         score_limit;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // numeric value of a request, digits above 9 counted as 9
  function automatic int req_value(input logic [4*D-1:0] b);
    int v, w;
    logic [3:0] d;
    v = 0;
    w = 1;
    for (int i = 0; i < D; i++) begin
      d = b[4*i +: 4];
      v += ((d > 4'd9) ? 9 : int'(d)) * w;
      w *= 10;
    end
    return v;
  endfunction

  task automatic model_step();
    if (!reset_n) begin
      m_score = 0; m_busy = 0; m_coins = 0; m_lives = LINI;
      m_debug = 8'h00; m_oneup = 0; m_sat = 0;
    end else begin
      if (debug_we) m_debug = debug_in;
      if (clear) begin
        m_score = 0; m_busy = 0; m_coins = 0; m_lives = LINI;
        m_oneup = 0; m_sat = 0;
      end else begin
        m_sat = 0;
        if (m_busy > 0) begin
          m_busy--;
          if (m_busy == 0) begin
            if (m_score + m_pend >= score_limit) begin
              m_score = score_limit - 1;
              m_sat = 1;
            end else begin
              m_score = m_score + m_pend;
            end
          end
        end else if (add_valid) begin
          m_pend = req_value(add_bcd);
          m_busy = D + 1;
        end
        m_oneup = 0;
        if (coin_inc) begin
          if (m_coins == 99) begin
            m_coins = 0;
            m_oneup = 1;
            if (m_lives < LMAX) m_lives++;
          end else begin
            m_coins++;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [D-1:0] exp_blank;
    int p;
    p = 1;
    exp_blank = '0;
    for (int i = 1; i < D; i++) begin
      p *= 10;
      exp_blank[i] = (m_score < p);
    end
    check("score", 32'(score_bcd), to_bcd(m_score));
    check("add_ready", 32'(add_ready), 32'(m_busy == 0));
    check("score_sat", 32'(score_sat), 32'(m_sat));
    check("score_blank", 32'(score_blank), 32'(exp_blank));
    check("coin", 32'(coin_bcd), to_bcd(m_coins));
    check("coin_blank", 32'(coin_blank), 32'({m_coins < 10, 1'b0}));
    check("lives", 32'(lives), 32'(m_lives));
    check("oneup", 32'(oneup), 32'(m_oneup));
    check("debug_q", 32'(debug_q), 32'(m_debug));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic req_add(input logic [4*D-1:0] b);
    int n;
    n = 0;
    while (m_busy != 0 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("add_wait_timeout", 32'(n), 32'(0));
    add_valid = 1'b1;
    add_bcd   = b;
    tick();
    add_valid = 1'b0;
    $display("add %h requested, score now %0d, model busy %0d", b, m_score, m_busy);
  endtask

  task automatic wait_idle();
    repeat (D + 2) tick();
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    $display("clear applied");
  endtask

  initial begin
    score_limit = 1;
    for (int i = 0; i < D; i++) score_limit *= 10;

    // reset
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    $display("reset released");

    // add 0123 from zero
    req_add(16'h0123);
    wait_idle();

    // carry ripple, then saturation
    clear_pulse();
    req_add(16'h0999); wait_idle();
    req_add(16'h0001); wait_idle();
    req_add(16'h9500); wait_idle();

    // 100 coins -> one 1-up
    clear_pulse();
    repeat (100) begin
      coin_inc = 1'b1; tick();
      coin_inc = 1'b0; tick();
    end
    $display("100 coins done: coins %0d lives %0d", m_coins, m_lives);

    // drive lives to saturation and roll once more at LIVES_MAX
    coin_inc = 1'b1;
    repeat (600) tick();
    coin_inc = 1'b0;
    tick();
    $display("600 coins done: coins %0d lives %0d", m_coins, m_lives);

    // add in flight with coin and debug activity; then an out-of-range digit
    clear_pulse();
    req_add(16'h0011);
    coin_inc = 1'b1; debug_we = 1'b1; debug_in = 8'hA5;
    tick();
    coin_inc = 1'b0; debug_we = 1'b0;
    wait_idle();
    req_add(16'h000F); wait_idle();

    // clear mid-add with coins 42 and debug 3C
    clear_pulse();
    coin_inc = 1'b1;
    repeat (42) tick();
    coin_inc = 1'b0;
    debug_we = 1'b1; debug_in = 8'h3C; tick(); debug_we = 1'b0;
    req_add(16'h0100);
    tick(); tick();
    clear_pulse();
    repeat (3) tick();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      add_valid = ($urandom_range(0, 3) == 0);
      add_bcd   = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom & 32'h00FF);
      coin_inc  = ($urandom_range(0, 1) == 0);
      debug_we  = ($urandom_range(0, 7) == 0);
      debug_in  = 8'($urandom);
      clear     = ($urandom_range(0, 99) == 0);
      reset_n   = ($urandom_range(0, 299) != 0);
      tick();
    end
    add_valid = 1'b0; coin_inc = 1'b0; debug_we = 1'b0; clear = 1'b0; reset_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hud_counter_bank.md
# hud_counter_bank

Parametrised heads-up-display counter bank for Super Gene Bros. It keeps the score as a BCD counter of configurable width with a serial BCD adder behind a valid/ready handshake, and a two-digit coin counter that rolls over into a lives counter (1-up). It also holds an 8-bit host/debug byte. All values come out as per-digit nibbles plus a leading-zero blank mask, ready for the per-digit hexdriver instances in the game top level.

## Interface
Parameters:
- SCORE_DIGITS, 4: number of BCD score digits (2..8).
- LIVES_INIT, 3: lives value after reset/clear (binary).
- LIVES_MAX, 9: lives saturation value (binary, ≤15).
- BLANK_LZ, 1: 1 = report leading-zero digits in blank masks; 0 = masks always 0.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset_n  in  1  reset; synchronous, active-low.
- clear  in  1  synchronous game clear (level, sampled each edge).
- add_valid  in  1  score-add request.
- add_ready  out  1  block can accept an add this cycle.
- add_bcd  in  4*SCORE_DIGITS  BCD amount to add; digit i at [4i+3:4i].
- coin_inc  in  1  one-cycle pulse: one coin collected.
- debug_we  in  1  latch debug_in.
- debug_in  in  8  host/debug byte.
- score_bcd  out  4*SCORE_DIGITS  committed score.
- coin_bcd  out  8  coins, 00..99.
- lives  out  4  lives, binary.
- debug_q  out  8  latched debug byte.
- oneup  out  1  one-cycle pulse on coin rollover.
- score_sat  out  1  one-cycle pulse when an add saturates.
- score_blank  out  SCORE_DIGITS  bit i = digit i is a leading zero.
- coin_blank  out  2  bit 1 = coin tens digit is zero.

## Operation
- Reset (reset_n=0 at an edge) sets score_bcd=0, coin_bcd=0x00, lives=LIVES_INIT, debug_q=0x00, oneup=0, score_sat=0, FSM=IDLE, add_ready=1.
- clear=1 applies the same values except debug_q, which is held. clear aborts any add in progress without committing. reset_n has priority over clear.
- Score FSM states: IDLE, ADD, COMMIT.
  - IDLE: add_ready=1. On add_valid&add_ready: capture add_bcd into op, idx=0, carry=0, work=0, go to ADD.
  - ADD: add_ready=0. Compute s = score digit[idx] + op digit[idx] + carry. If s>9: work[idx]=s-10, carry=1; else work[idx]=s, carry=0. Increment idx. After digit SCORE_DIGITS-1, go to COMMIT.
  - COMMIT: add_ready=0. If carry=1: score = all 9s and score_sat pulses. Otherwise score = work. Go to IDLE.
- Any op digit >9 is clamped to 9 before the add.
- score_bcd changes only in COMMIT; partial sums are never visible.
- coin_inc is independent of the FSM and accepted in every state.
  - 99 + 1 → 00 and oneup pulses.
  - On oneup, lives increments, saturating at LIVES_MAX. oneup pulses even when lives is already saturated.
  - A coin_inc in the same cycle as clear is dropped.
- debug_we=1 loads debug_q=debug_in on that edge.
- Blank masks are combinational from registered values.
  - score_blank[i]=1 iff BLANK_LZ=1, i>0, and digits i..SCORE_DIGITS-1 are all zero. Digit 0 is never blanked.
  - coin_blank[1]=1 iff BLANK_LZ=1 and the coin tens digit is zero. coin_blank[0] is always 0.

## Timing
- Add latency: request accepted at edge N. ADD occupies edges N+1..N+SCORE_DIGITS, and COMMIT is edge N+SCORE_DIGITS+1. The new score is visible right after that edge.
- add_ready is high again in the cycle after COMMIT, so the minimum add-to-add spacing is SCORE_DIGITS+2 cycles.
- add_valid while add_ready=0 is ignored; the requester holds add_valid until it sees ready.
- coin_inc → coin_bcd, oneup and lives are all updated at the same edge (1-cycle latency). oneup is high for exactly one cycle.
- score_sat is high for exactly one cycle, in the cycle following COMMIT.
- clear asserted during ADD: FSM is IDLE and add_ready=1 after that edge; score=0.
- reset_n deasserted mid-add: same result as clear, and debug_q=0.

## Test plan
- Reset, then add 0x0123 (SCORE_DIGITS=4) → add_ready low 5 cycles; score_bcd=0x0123 at edge N+5; score_blank=4'b1000.
- Score 0x0999, add 0x0001 → 0x1000 via carry ripple; then add 0x9500 → saturates at 0x9999 with one score_sat pulse.
- 100 coin_inc pulses starting from lives=3 → coin_bcd=00 after the 100th; oneup once; lives=4; coin_blank=2'b10 at 05.
- Lives at LIVES_MAX=9, coin 99, coin_inc → coins 00, oneup pulses, lives stays 9.
- Add in flight plus simultaneous coin_inc and debug_we=1 with 0xA5 → coins update next edge, debug_q=0xA5, add commits unaffected; then add_bcd digit 0xF → treated as 9.
- clear mid-ADD with coins 42, debug_q 0x3C → score 0, coins 00, lives 3, debug_q 0x3C, add_ready=1 next cycle; no score_sat pulse.
